// File: rtl/egm_pkg.sv
// Shared state encoding and parameter defaults for the EGM latency tester.
package egm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STIM_HI = 2'd1,
        STIM_LO = 2'd2
    } state_e;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/egm_tester_if.sv
// Signal bundle for driving and observing one egm_tester instance.
interface egm_tester_if
    import egm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse_width;
    logic             stimulus;
    logic             response;
    logic [CNT_W-1:0] latency;
    logic             latency_valid;
    logic [CNT_W-1:0] pulse_count;
    logic [CNT_W-1:0] missed_count;
    logic [CNT_W-1:0] spurious_count;
    logic [CNT_W-1:0] max_latency;
    logic             busy;

    modport master (
        output enable, period, pulse_width, response,
        input  stimulus, latency, latency_valid, pulse_count,
               missed_count, spurious_count, max_latency, busy
    );

    modport slave (
        input  enable, period, pulse_width, response,
        output stimulus, latency, latency_valid, pulse_count,
               missed_count, spurious_count, max_latency, busy
    );

endinterface

// File: rtl/egm_sync.sv
// Multi-flop synchronizer for the asynchronous response line, followed by a
// registered rising-edge detector (one-cycle pulse per synchronized 0->1).
module egm_sync
    import egm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            // Shift in at bit 0; the cast drops the oldest bit and also covers SYNC_STAGES == 1.
            sync_q <= SYNC_STAGES'({sync_q, async_i});
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/egm_tester.sv
// Periodic stimulus generator that measures the latency of an asynchronous
// response and keeps pulse / missed / spurious / max-latency statistics.
module egm_tester
    import egm_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_50_clk,
    input  logic             reset_reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pulse_width,
    output logic             stimulus,
    input  logic             response,
    output logic [CNT_W-1:0] latency,
    output logic             latency_valid,
    output logic [CNT_W-1:0] pulse_count,
    output logic [CNT_W-1:0] missed_count,
    output logic [CNT_W-1:0] spurious_count,
    output logic [CNT_W-1:0] max_latency,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_X = (CNT_W+1)'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pw_last_q, pw_last_d;
    logic [CNT_W-1:0] per_last_q, per_last_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] missed_q, missed_d;
    logic [CNT_W-1:0] spur_q, spur_d;
    logic             stim_q, stim_d;
    logic             armed_q, armed_d;
    logic             lv_q, lv_d;
    logic             rise;

    logic [CNT_W:0]   eff_pw_x, eff_per_x;
    logic [CNT_W-1:0] start_pw_last, start_per_last;

    egm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_50_clk),
        .rst_ni (reset_reset_n),
        .async_i(response),
        .rise_o (rise)
    );

    // Terminal counts are kept as "last index" so eff_pw+1 never needs an extra stored bit.
    always_comb begin
        eff_pw_x       = (pulse_width == '0) ? ONE_X : {1'b0, pulse_width};
        eff_per_x      = ({1'b0, period} > eff_pw_x) ? {1'b0, period} : eff_pw_x + ONE_X;
        start_pw_last  = CNT_W'(eff_pw_x - ONE_X);
        start_per_last = CNT_W'(eff_per_x - ONE_X);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pw_last_d  = pw_last_q;
        per_last_d = per_last_q;
        lat_cnt_d  = lat_cnt_q;
        latency_d  = latency_q;
        max_d      = max_q;
        pulse_d    = pulse_q;
        missed_d   = missed_q;
        spur_d     = spur_q;
        armed_d    = armed_q;
        lv_d       = 1'b0;

        if (armed_q) begin
            lat_cnt_d = sat_inc(lat_cnt_q);
        end

        if (rise) begin
            if (armed_q) begin
                latency_d = lat_cnt_q;
                lv_d      = 1'b1;
                armed_d   = 1'b0;
                if (lat_cnt_q > max_q) begin
                    max_d = lat_cnt_q;
                end
            end else begin
                spur_d = sat_inc(spur_q);
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = STIM_HI;
                    cnt_d      = '0;
                    pw_last_d  = start_pw_last;
                    per_last_d = start_per_last;
                    lat_cnt_d  = '0;
                    armed_d    = 1'b1;
                    pulse_d    = ONE;
                    missed_d   = '0;
                    spur_d     = '0;
                    max_d      = '0;
                end
            end
            STIM_HI: begin
                if (!enable) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == pw_last_q) begin
                        state_d = STIM_LO;
                    end
                end
            end
            STIM_LO: begin
                if (!enable) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else if (cnt_q == per_last_q) begin
                    // A response landing in the wrap cycle was credited above, so it is not a miss.
                    if (armed_q && !rise) begin
                        missed_d = sat_inc(missed_q);
                    end
                    state_d    = STIM_HI;
                    cnt_d      = '0;
                    pw_last_d  = start_pw_last;
                    per_last_d = start_per_last;
                    lat_cnt_d  = '0;
                    armed_d    = 1'b1;
                    pulse_d    = sat_inc(pulse_q);
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
        endcase

        stim_d = (state_d == STIM_HI);
    end

    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pw_last_q  <= '0;
            per_last_q <= '0;
            lat_cnt_q  <= '0;
            latency_q  <= '0;
            max_q      <= '0;
            pulse_q    <= '0;
            missed_q   <= '0;
            spur_q     <= '0;
            stim_q     <= 1'b0;
            armed_q    <= 1'b0;
            lv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pw_last_q  <= pw_last_d;
            per_last_q <= per_last_d;
            lat_cnt_q  <= lat_cnt_d;
            latency_q  <= latency_d;
            max_q      <= max_d;
            pulse_q    <= pulse_d;
            missed_q   <= missed_d;
            spur_q     <= spur_d;
            stim_q     <= stim_d;
            armed_q    <= armed_d;
            lv_q       <= lv_d;
        end
    end

    assign stimulus       = stim_q;
    assign latency        = latency_q;
    assign latency_valid  = lv_q;
    assign pulse_count    = pulse_q;
    assign missed_count   = missed_q;
    assign spurious_count = spur_q;
    assign max_latency    = max_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_egm_tester.sv
// Bench for egm_tester: directed and randomized scenarios scored against a
// per-pulse arithmetic model of the stimulus timing and response accounting.
module tb_egm_tester;

    localparam int unsigned CW = 16;
    localparam int          SS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int last_lat = 0;

    // Response high intervals, inclusive, as sampled-edge indices relative to edge 0 of a run.
    int rs[$];
    int re[$];

    always #10 clk = ~clk;

    egm_tester_if #(.CNT_W(CW)) bus ();

    egm_tester #(
        .CNT_W      (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_50_clk    (clk),
        .reset_reset_n (rst_n),
        .enable        (bus.enable),
        .period        (bus.period),
        .pulse_width   (bus.pulse_width),
        .stimulus      (bus.stimulus),
        .response      (bus.response),
        .latency       (bus.latency),
        .latency_valid (bus.latency_valid),
        .pulse_count   (bus.pulse_count),
        .missed_count  (bus.missed_count),
        .spurious_count(bus.spurious_count),
        .max_latency   (bus.max_latency),
        .busy          (bus.busy)
    );

    function automatic logic resp_at(input int k);
        foreach (rs[i]) begin
            if (k >= rs[i] && k <= re[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int eff_w(input int pw);
        return (pw == 0) ? 1 : pw;
    endfunction

    function automatic int eff_p(input int per, input int pw);
        return (per > eff_w(pw)) ? per : eff_w(pw) + 1;
    endfunction

    task automatic go_idle();
        bus.enable   = 1'b0;
        bus.response = 1'b0;
        repeat (SS + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enable      = 1'b0;
        bus.period      = '0;
        bus.pulse_width = '0;
        bus.response    = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.stimulus !== 1'b0) begin errors++; $display("FAIL reset stimulus: got %b expected 0", bus.stimulus); end
        checks++; if (bus.latency !== 0) begin errors++; $display("FAIL reset latency: got %0d expected 0", bus.latency); end
        checks++; if (bus.latency_valid !== 1'b0) begin errors++; $display("FAIL reset latency_valid: got %b expected 0", bus.latency_valid); end
        checks++; if (bus.pulse_count !== 0) begin errors++; $display("FAIL reset pulse_count: got %0d expected 0", bus.pulse_count); end
        checks++; if (bus.missed_count !== 0) begin errors++; $display("FAIL reset missed_count: got %0d expected 0", bus.missed_count); end
        checks++; if (bus.spurious_count !== 0) begin errors++; $display("FAIL reset spurious_count: got %0d expected 0", bus.spurious_count); end
        checks++; if (bus.max_latency !== 0) begin errors++; $display("FAIL reset max_latency: got %0d expected 0", bus.max_latency); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        last_lat = 0;
    endtask

    // Runs n full periods with fixed settings and the response intervals in rs/re,
    // checking stimulus and pulse_count every cycle and the statistics at edge n*P.
    task automatic run_scenario(input string name, input int per, input int pw, input int n);
        int W, P, L, spur, missed, maxl, d, p, e, v, exp_pulse;
        bit answered[];
        int lv_edge[$];
        int lv_val[$];
        logic exp_stim;
        W = eff_w(pw);
        P = eff_p(per, pw);
        L = n * P;
        spur = 0; missed = 0; maxl = 0;
        answered = new[n];
        foreach (rs[i]) begin
            d = rs[i] + SS;
            p = d / P;
            if (!answered[p]) begin
                answered[p] = 1'b1;
                lv_edge.push_back(d + 1);
                lv_val.push_back(d - p * P);
                last_lat = d - p * P;
                if (d - p * P > maxl) maxl = d - p * P;
            end else begin
                spur++;
            end
        end
        foreach (answered[i]) if (!answered[i]) missed++;

        @(negedge clk);
        bus.period      = CW'(per);
        bus.pulse_width = CW'(pw);
        bus.response    = 1'b0;
        bus.enable      = 1'b1;
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            exp_stim  = ((k % P) < W);
            exp_pulse = k / P + 1;
            checks++;
            if (bus.stimulus !== exp_stim) begin
                errors++;
                $display("FAIL %s stimulus edge %0d: got %b expected %b", name, k, bus.stimulus, exp_stim);
            end
            checks++;
            if (bus.pulse_count !== exp_pulse) begin
                errors++;
                $display("FAIL %s pulse_count edge %0d: got %0d expected %0d", name, k, bus.pulse_count, exp_pulse);
            end
            if (bus.latency_valid === 1'b1) begin
                checks++;
                if (lv_edge.size() == 0) begin
                    errors++;
                    $display("FAIL %s latency_valid edge %0d: got 1 expected 0", name, k);
                end else begin
                    e = lv_edge.pop_front();
                    v = lv_val.pop_front();
                    if (k !== e || bus.latency !== v) begin
                        errors++;
                        $display("FAIL %s latency pulse: got edge %0d value %0d expected edge %0d value %0d",
                                 name, k, bus.latency, e, v);
                    end
                end
            end
            bus.response = resp_at(k + 1);
        end
        checks++; if (lv_edge.size() != 0) begin errors++; $display("FAIL %s latency_valid count: got %0d pulses outstanding expected 0", name, lv_edge.size()); end
        checks++; if (bus.latency !== last_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, bus.latency, last_lat); end
        checks++; if (bus.max_latency !== maxl) begin errors++; $display("FAIL %s max_latency: got %0d expected %0d", name, bus.max_latency, maxl); end
        checks++; if (bus.missed_count !== missed) begin errors++; $display("FAIL %s missed_count: got %0d expected %0d", name, bus.missed_count, missed); end
        checks++; if (bus.spurious_count !== spur) begin errors++; $display("FAIL %s spurious_count: got %0d expected %0d", name, bus.spurious_count, spur); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", name, bus.busy); end
        go_idle();
    endtask

    task automatic test_basic();
        rs = '{20}; re = '{24};
        run_scenario("basic", 100, 10, 1);
    endtask

    task automatic test_missed();
        rs.delete(); re.delete();
        run_scenario("missed", 100, 10, 2);
    endtask

    task automatic test_clamp_period();
        rs.delete(); re.delete();
        run_scenario("clamp", 5, 9, 3);
    endtask

    task automatic test_zero_settings();
        rs.delete(); re.delete();
        run_scenario("zero", 0, 0, 4);
    endtask

    task automatic test_double_response();
        rs = '{5, 20}; re = '{8, 22};
        run_scenario("double", 60, 8, 1);
    endtask

    task automatic test_wrap_edge();
        rs = '{47, 60}; re = '{52, 62};
        run_scenario("wrap", 50, 10, 2);
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int per, pw, n, P, L, t, cnt, len;
            per = $urandom_range(0, 40);
            pw  = $urandom_range(0, 24);
            n   = $urandom_range(1, 3);
            P   = eff_p(per, pw);
            L   = n * P;
            rs.delete(); re.delete();
            t   = $urandom_range(1, 6);
            cnt = $urandom_range(0, 4);
            for (int j = 0; j < cnt; j++) begin
                if (t + SS > L - 1) break;
                len = $urandom_range(1, 6);
                rs.push_back(t);
                re.push_back(t + len - 1);
                t = t + len + $urandom_range(1, P);
            end
            run_scenario($sformatf("rand%0d", it), per, pw, n);
        end
    endtask

    task automatic test_disable();
        rs = '{3}; re = '{6};
        @(negedge clk);
        bus.period      = CW'(40);
        bus.pulse_width = CW'(12);
        bus.response    = 1'b0;
        bus.enable      = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (bus.latency_valid !== 1'b1 || bus.latency !== 5) begin
                    errors++;
                    $display("FAIL disable latency: got valid %b value %0d expected valid 1 value 5", bus.latency_valid, bus.latency);
                end
            end
            bus.response = resp_at(k + 1);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.stimulus !== 1'b0) begin errors++; $display("FAIL disable stimulus: got %b expected 0", bus.stimulus); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL disable busy: got %b expected 0", bus.busy); end
        repeat (60) @(negedge clk);
        checks++; if (bus.pulse_count !== 1) begin errors++; $display("FAIL disable pulse_count: got %0d expected 1", bus.pulse_count); end
        checks++; if (bus.missed_count !== 0) begin errors++; $display("FAIL disable missed_count: got %0d expected 0", bus.missed_count); end
        checks++; if (bus.latency !== 5) begin errors++; $display("FAIL disable latency held: got %0d expected 5", bus.latency); end
        checks++; if (bus.stimulus !== 1'b0) begin errors++; $display("FAIL disable stimulus idle: got %b expected 0", bus.stimulus); end
        last_lat = 5;
    endtask

    task automatic test_reset_mid_pulse();
        rs = '{2}; re = '{3};
        @(negedge clk);
        bus.period      = CW'(30);
        bus.pulse_width = CW'(20);
        bus.response    = 1'b0;
        bus.enable      = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (bus.latency !== 4) begin errors++; $display("FAIL rstmid latency before reset: got %0d expected 4", bus.latency); end
            end
            bus.response = resp_at(k + 1);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.stimulus !== 1'b0) begin errors++; $display("FAIL rstmid stimulus: got %b expected 0", bus.stimulus); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", bus.busy); end
        checks++; if (bus.latency !== 0) begin errors++; $display("FAIL rstmid latency: got %0d expected 0", bus.latency); end
        checks++; if (bus.pulse_count !== 0) begin errors++; $display("FAIL rstmid pulse_count: got %0d expected 0", bus.pulse_count); end
        checks++; if (bus.max_latency !== 0) begin errors++; $display("FAIL rstmid max_latency: got %0d expected 0", bus.max_latency); end
        bus.enable   = 1'b0;
        bus.response = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.stimulus !== 1'b0) begin errors++; $display("FAIL rstmid idle after release: got busy %b stimulus %b expected 0 0", bus.busy, bus.stimulus); end
        bus.enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.pulse_count !== 1) begin errors++; $display("FAIL rstmid restart pulse_count: got %0d expected 1", bus.pulse_count); end
        checks++; if (bus.stimulus !== 1'b1) begin errors++; $display("FAIL rstmid restart stimulus: got %b expected 1", bus.stimulus); end
        last_lat = 0;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_missed();
        test_clamp_period();
        test_zero_settings();
        test_double_response();
        test_wrap_edge();
        test_random(8);
        test_disable();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
